// File: rtl/mode_led_selector_pkg.sv
// Shared definitions for the front-panel mode selector: debounce default,
// DDS waveform enumeration and the one-hot LED encoder.
package mode_led_selector_pkg;

    localparam int DEBOUNCE_DEFAULT = 1000000;
    localparam int MAX_MODES        = 16;

    typedef enum logic [1:0] {
        SINE     = 2'd0,
        SQUARE   = 2'd1,
        TRIANGLE = 2'd2,
        SAWTOOTH = 2'd3
    } dds_mode_e;

    // With msb_first set, mode 0 lights the highest LED of an n_modes-wide bar.
    function automatic logic [MAX_MODES-1:0] onehot(
        input logic [3:0] idx,
        input int         n_modes,
        input logic       msb_first
    );
        int pos;
        if (msb_first) begin
            pos = n_modes - 1 - int'(idx);
        end else begin
            pos = int'(idx);
        end
        return 16'd1 << pos;
    endfunction

endpackage

// File: rtl/mode_led_selector_key_debounce.sv
// Synchronises and debounces one raw push-button and emits a one-cycle
// pulse for each accepted press (stable 0->1 transition).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_stable,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             stable_d_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchroniser, debounce counter and press edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            press_r    <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            sync1_r    <= key_raw;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            press_r    <= stable_r & ~stable_d_r;
            // Any sample matching the accepted level restarts the stability window.
            if (sync2_r == stable_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= sync2_r;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign key_stable = stable_r;
    assign press      = press_r;

endmodule

// File: rtl/mode_led_selector.sv
// Front-panel mode selector: debounced next/prev keys plus a direct load
// path drive a registered mode index, one-hot LED bar and change strobe.
module mode_led_selector
    import mode_led_selector_pkg::*;
#(
    parameter int N_MODES         = 4,
    parameter int IDX_W           = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 20,
    parameter int WRAP            = 1,
    parameter int RESET_MODE      = 0,
    parameter int MSB_FIRST       = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_next,
    input  logic               key_prev,
    input  logic               load_en,
    input  logic [IDX_W-1:0]   load_idx,
    output logic [IDX_W-1:0]   mode_idx,
    output logic [N_MODES-1:0] led,
    output logic               mode_chg
);

    localparam logic [IDX_W:0]     N_EXT     = (IDX_W + 1)'(N_MODES);
    localparam logic [IDX_W:0]     LAST_EXT  = (IDX_W + 1)'(N_MODES - 1);
    localparam logic [IDX_W-1:0]   RESET_IDX = IDX_W'(RESET_MODE);
    localparam logic [N_MODES-1:0] RESET_LED =
        N_MODES'(onehot(4'(RESET_MODE), N_MODES, MSB_FIRST != 0));

    logic               next_press_s;
    logic               prev_press_s;
    logic [1:0]         keys_stable_unused_s;
    logic [IDX_W:0]     idx_ext_s;
    logic [IDX_W:0]     step_ext_s;
    logic [IDX_W-1:0]   next_idx_s;
    logic [N_MODES-1:0] led_next_s;
    logic               mode_chg_s;
    logic [IDX_W-1:0]   mode_idx_r;
    logic [N_MODES-1:0] led_r;
    logic               mode_chg_r;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_next (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_next),
        .key_stable (keys_stable_unused_s[0]),
        .press      (next_press_s)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_prev (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_prev),
        .key_stable (keys_stable_unused_s[1]),
        .press      (prev_press_s)
    );

    // Next-index selection; the extra bit keeps non-power-of-two ranges in bounds.
    always_comb begin
        idx_ext_s  = {1'b0, mode_idx_r};
        step_ext_s = idx_ext_s;
        if (load_en) begin
            if ({1'b0, load_idx} < N_EXT) begin
                step_ext_s = {1'b0, load_idx};
            end else begin
                step_ext_s = idx_ext_s;
            end
        end else if (next_press_s && prev_press_s) begin
            step_ext_s = idx_ext_s;
        end else if (next_press_s) begin
            if (idx_ext_s == LAST_EXT) begin
                step_ext_s = (WRAP != 0) ? {(IDX_W + 1){1'b0}} : idx_ext_s;
            end else begin
                step_ext_s = idx_ext_s + (IDX_W + 1)'(1);
            end
        end else if (prev_press_s) begin
            if (idx_ext_s == {(IDX_W + 1){1'b0}}) begin
                step_ext_s = (WRAP != 0) ? LAST_EXT : idx_ext_s;
            end else begin
                step_ext_s = idx_ext_s - (IDX_W + 1)'(1);
            end
        end else begin
            step_ext_s = idx_ext_s;
        end
        next_idx_s = IDX_W'(step_ext_s);
        mode_chg_s = (next_idx_s != mode_idx_r);
    end

    assign led_next_s = N_MODES'(onehot(4'(next_idx_s), N_MODES, MSB_FIRST != 0));

    // Registered index, LED bar and change strobe all update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_idx_r <= RESET_IDX;
            led_r      <= RESET_LED;
            mode_chg_r <= 1'b0;
        end else begin
            mode_idx_r <= next_idx_s;
            led_r      <= led_next_s;
            mode_chg_r <= mode_chg_s;
        end
    end

    assign mode_idx = mode_idx_r;
    assign led      = led_r;
    assign mode_chg = mode_chg_r;

endmodule
